// File: rtl/apb_emulator.sv
`timescale 1ns/1ps
// Self-sequencing APB master: writes a pattern, reads it back and compares,
// then reports mismatch/slave-error counts with one summary write and idles until reset.
module apb_emulator #(
  parameter int unsigned NUM_TRANS      = 8,
  parameter int unsigned START_DELAY    = 2,
  parameter logic [31:0] SUMMARY_OFFSET = 32'h0000_0100,
  parameter logic [2:0]  PROT           = 3'b000
) (
  input  logic        apb_clk_i,
  input  logic        apb_resetn_i,
  output logic        apb_clk_en_o,
  output logic [31:0] apb_addr_o,
  output logic        apb_sel_o,
  output logic        apb_enable_o,
  output logic        apb_write_o,
  output logic [3:0]  apb_strb_o,
  output logic [2:0]  apb_prot_o,
  output logic [31:0] apb_wdata_o,
  input  logic        apb_ready_i,
  input  logic [31:0] apb_rdata_i,
  input  logic        apb_slverr_i,
  input  logic [31:0] emulator_id_i
);

  localparam int unsigned IDX_W = 16;
  localparam int unsigned CNT_W = 16;
  localparam int unsigned DLY_W = 16;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_TRANS - 1);
  localparam logic [DLY_W-1:0] LAST_DLY = DLY_W'(START_DELAY - 1);
  localparam logic [CNT_W-1:0] CNT_MAX  = '1;

  typedef enum logic [2:0] {ST_START, ST_SETUP, ST_ACCESS, ST_GAP, ST_DONE} state_t;
  typedef enum logic [1:0] {PH_WRITE, PH_READ, PH_SUMMARY} phase_t;

  state_t           state;
  phase_t           phase;
  logic [IDX_W-1:0] idx;
  logic [DLY_W-1:0] dly_cnt;
  logic [31:0]      base;
  logic [CNT_W-1:0] mismatch_cnt;
  logic [CNT_W-1:0] slverr_cnt;

  phase_t           nxt_phase;
  logic [IDX_W-1:0] nxt_idx;
  logic             nxt_done;
  logic [31:0]      nxt_addr;
  logic [31:0]      nxt_wdata;
  logic             nxt_write;
  logic [31:0]      exp_rdata;

  // Parameters of the transfer that follows the current one (used leaving GAP)
  always_comb begin
    nxt_phase = phase;
    nxt_idx   = idx;
    nxt_done  = 1'b0;
    case (phase)
      PH_WRITE: begin
        if (idx == LAST_IDX) begin
          nxt_phase = PH_READ;
          nxt_idx   = '0;
        end else begin
          nxt_idx = idx + IDX_W'(1);
        end
      end
      PH_READ: begin
        if (idx == LAST_IDX) begin
          nxt_phase = PH_SUMMARY;
          nxt_idx   = '0;
        end else begin
          nxt_idx = idx + IDX_W'(1);
        end
      end
      default: nxt_done = 1'b1;
    endcase

    nxt_addr  = base + {14'b0, nxt_idx, 2'b00};
    nxt_wdata = {16'hA5A5, nxt_idx} ^ base;
    nxt_write = 1'b1;
    if (nxt_phase == PH_READ) begin
      nxt_write = 1'b0;
      nxt_wdata = '0;
    end else if (nxt_phase == PH_SUMMARY) begin
      nxt_addr  = base + SUMMARY_OFFSET;
      nxt_wdata = {slverr_cnt, mismatch_cnt};
    end
  end

  assign exp_rdata = {16'hA5A5, idx} ^ base;

  // Sequencer with registered bus outputs
  always_ff @(posedge apb_clk_i or negedge apb_resetn_i) begin
    if (!apb_resetn_i) begin
      state        <= ST_START;
      phase        <= PH_WRITE;
      idx          <= '0;
      dly_cnt      <= '0;
      base         <= '0;
      mismatch_cnt <= '0;
      slverr_cnt   <= '0;
      apb_clk_en_o <= 1'b0;
      apb_addr_o   <= '0;
      apb_sel_o    <= 1'b0;
      apb_enable_o <= 1'b0;
      apb_write_o  <= 1'b0;
      apb_strb_o   <= '0;
      apb_prot_o   <= '0;
      apb_wdata_o  <= '0;
    end else begin
      case (state)
        ST_START: begin
          if (dly_cnt == LAST_DLY) begin
            state        <= ST_SETUP;
            base         <= emulator_id_i;
            phase        <= PH_WRITE;
            idx          <= '0;
            apb_clk_en_o <= 1'b1;
            apb_addr_o   <= emulator_id_i;
            apb_sel_o    <= 1'b1;
            apb_enable_o <= 1'b0;
            apb_write_o  <= 1'b1;
            apb_strb_o   <= 4'hF;
            apb_prot_o   <= PROT;
            apb_wdata_o  <= 32'hA5A5_0000 ^ emulator_id_i;
          end else begin
            dly_cnt <= dly_cnt + DLY_W'(1);
          end
        end
        ST_SETUP: begin
          state        <= ST_ACCESS;
          apb_enable_o <= 1'b1;
        end
        ST_ACCESS: begin
          if (apb_ready_i) begin
            state        <= ST_GAP;
            apb_sel_o    <= 1'b0;
            apb_enable_o <= 1'b0;
            if (phase != PH_SUMMARY && apb_slverr_i && slverr_cnt != CNT_MAX)
              slverr_cnt <= slverr_cnt + CNT_W'(1);
            if (phase == PH_READ && apb_rdata_i != exp_rdata && mismatch_cnt != CNT_MAX)
              mismatch_cnt <= mismatch_cnt + CNT_W'(1);
          end
        end
        ST_GAP: begin
          if (nxt_done) begin
            state        <= ST_DONE;
            apb_clk_en_o <= 1'b0;
            apb_addr_o   <= '0;
            apb_write_o  <= 1'b0;
            apb_strb_o   <= '0;
            apb_prot_o   <= '0;
            apb_wdata_o  <= '0;
          end else begin
            state       <= ST_SETUP;
            phase       <= nxt_phase;
            idx         <= nxt_idx;
            apb_sel_o   <= 1'b1;
            apb_addr_o  <= nxt_addr;
            apb_write_o <= nxt_write;
            apb_wdata_o <= nxt_wdata;
          end
        end
        ST_DONE: state <= ST_DONE;
        default: state <= ST_START;
      endcase
    end
  end

endmodule

// File: tb/tb_apb_emulator.sv
`timescale 1ns/1ps
// Directed bench for apb_emulator: a negedge-driven APB slave with optional
// loop-back memory, wait-state and error injection, plus a transfer log.
module tb_apb_emulator;

  logic        clk;
  logic        rst_n;
  logic        clk_en;
  logic [31:0] addr;
  logic        sel;
  logic        enable;
  logic        write;
  logic [3:0]  strb;
  logic [2:0]  prot;
  logic [31:0] wdata;
  logic        ready;
  logic [31:0] rdata;
  logic        slverr;
  logic [31:0] emulator_id;

  int tests = 0;
  int errs  = 0;

  // Slave configuration
  bit          mem_mode = 0;
  logic [31:0] cur_base = '0;
  logic [7:0]  err_mask = '0;
  logic [31:0] wait_addr = '0;
  int          wait_n = 0;
  int          wait_cnt = 0;
  logic [31:0] mem [logic [31:0]];

  logic [31:0] log_addr[$];
  logic [31:0] log_wdata[$];
  logic        log_write[$];

  apb_emulator dut (
    .apb_clk_i    (clk),
    .apb_resetn_i (rst_n),
    .apb_clk_en_o (clk_en),
    .apb_addr_o   (addr),
    .apb_sel_o    (sel),
    .apb_enable_o (enable),
    .apb_write_o  (write),
    .apb_strb_o   (strb),
    .apb_prot_o   (prot),
    .apb_wdata_o  (wdata),
    .apb_ready_i  (ready),
    .apb_rdata_i  (rdata),
    .apb_slverr_i (slverr),
    .emulator_id_i(emulator_id)
  );

  initial clk = 1'b0;
  always #1 clk = ~clk;

  // Slave response and completed-transfer log, evaluated mid-cycle
  always @(negedge clk) begin
    logic [31:0] off;
    ready  = 1'b1;
    slverr = 1'b0;
    rdata  = '0;
    if (rst_n && sel && enable) begin
      if (wait_n > 0 && write && addr == wait_addr && wait_cnt < wait_n) begin
        ready = 1'b0;
        wait_cnt++;
      end
      if (!write) begin
        if (mem_mode && mem.exists(addr)) rdata = mem[addr];
        off = addr - cur_base;
        if (off < 32 && err_mask[off[4:2]]) slverr = 1'b1;
      end
      if (ready) begin
        log_addr.push_back(addr);
        log_wdata.push_back(wdata);
        log_write.push_back(write);
        if (write && mem_mode) mem[addr] = wdata;
      end
    end
  end

  function automatic logic [31:0] exp_addr(input logic [31:0] b, input int i);
    if (i < 8)       return b + 32'(4 * i);
    else if (i < 16) return b + 32'(4 * (i - 8));
    else             return b + 32'h0000_0100;
  endfunction

  function automatic logic [31:0] exp_wdata(input logic [31:0] b, input int i,
                                            input logic [31:0] summary);
    if (i < 8)       return {16'hA5A5, 16'(i)} ^ b;
    else if (i < 16) return 32'h0;
    else             return summary;
  endfunction

  task automatic clear_log();
    log_addr.delete();
    log_wdata.delete();
    log_write.delete();
  endtask

  task automatic start_seq(input logic [31:0] id, input bit mm);
    rst_n = 1'b0;
    @(negedge clk);
    mem.delete();
    clear_log();
    mem_mode    = mm;
    emulator_id = id;
    cur_base    = id;
    wait_cnt    = 0;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic wait_done(input int limit, output int cycles, output bit timed_out);
    bit seen = 0;
    cycles    = 0;
    timed_out = 1;
    for (int i = 0; i < limit; i++) begin
      @(negedge clk);
      cycles++;
      if (clk_en) seen = 1;
      else if (seen) begin
        timed_out = 0;
        break;
      end
    end
  endtask

  task automatic test_reset();
    rst_n       = 1'b0;
    emulator_id = '0;
    #5;
    tests++;
    if ({clk_en, addr, sel, enable, write, strb, prot, wdata} !== '0) begin
      errs++;
      $display("FAIL reset_outputs got addr=%h sel=%b en=%b wr=%b strb=%h prot=%h wd=%h clk_en=%b exp all zero",
               addr, sel, enable, write, strb, prot, wdata, clk_en);
    end
    #1.6 rst_n = 1'b1;
  endtask

  task automatic test_basic();
    int cycles;
    bit to;
    @(posedge clk); #0.5;
    tests++;
    if (sel !== 1'b0 || clk_en !== 1'b0) begin
      errs++;
      $display("FAIL basic_early_setup got sel=%b clk_en=%b exp 0 0", sel, clk_en);
    end
    @(posedge clk); #0.5;
    tests++;
    if ({sel, enable, write, addr, wdata, strb, prot, clk_en} !==
        {1'b1, 1'b0, 1'b1, 32'h0, 32'hA5A5_0000, 4'hF, 3'b000, 1'b1}) begin
      errs++;
      $display("FAIL basic_first_setup got sel=%b en=%b wr=%b addr=%h wd=%h strb=%h clk_en=%b exp 1 0 1 00000000 a5a50000 f 1",
               sel, enable, write, addr, wdata, strb, clk_en);
    end
    wait_done(100, cycles, to);
    tests++;
    if (to || cycles >= 60) begin
      errs++;
      $display("FAIL basic_timing got cycles=%0d timeout=%b exp <60 no timeout", cycles, to);
    end
    tests++;
    if (log_addr.size() != 17) begin
      errs++;
      $display("FAIL basic_count got %0d exp 17", log_addr.size());
    end
    for (int i = 0; i < 17 && i < log_addr.size(); i++) begin
      tests++;
      if (log_addr[i] !== exp_addr(32'h0, i) || log_write[i] !== (i < 8 || i == 16) ||
          log_wdata[i] !== exp_wdata(32'h0, i, 32'h0000_0008)) begin
        errs++;
        $display("FAIL basic_xfer%0d got addr=%h wr=%b wd=%h exp addr=%h wr=%b wd=%h", i,
                 log_addr[i], log_write[i], log_wdata[i], exp_addr(32'h0, i),
                 (i < 8 || i == 16), exp_wdata(32'h0, i, 32'h0000_0008));
      end
    end
  endtask

  task automatic test_memory();
    int cycles;
    bit to;
    start_seq(32'h0000_1000, 1'b1);
    wait_done(200, cycles, to);
    tests++;
    if (to || log_addr.size() != 17) begin
      errs++;
      $display("FAIL mem_done got count=%0d timeout=%b exp 17 no timeout", log_addr.size(), to);
    end
    for (int i = 0; i < 17 && i < log_addr.size(); i++) begin
      tests++;
      if (log_addr[i] !== exp_addr(32'h1000, i) || log_write[i] !== (i < 8 || i == 16) ||
          log_wdata[i] !== exp_wdata(32'h1000, i, 32'h0)) begin
        errs++;
        $display("FAIL mem_xfer%0d got addr=%h wr=%b wd=%h exp addr=%h wd=%h", i,
                 log_addr[i], log_write[i], log_wdata[i], exp_addr(32'h1000, i),
                 exp_wdata(32'h1000, i, 32'h0));
      end
    end
  endtask

  task automatic test_wait_states();
    int cycles;
    bit to;
    bit found = 0;
    logic [31:0] cap_wd;
    wait_addr = 32'h0000_3008;
    wait_n    = 3;
    start_seq(32'h0000_3000, 1'b1);
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (sel && enable && write && addr == 32'h0000_3008) begin
        found = 1;
        break;
      end
    end
    tests++;
    if (!found) begin
      errs++;
      $display("FAIL wait_reach got no access to 00003008 exp access within 100 cycles");
    end else begin
      cap_wd = wdata;
      tests++;
      if (cap_wd !== 32'hA5A5_3002) begin
        errs++;
        $display("FAIL wait_wdata got %h exp a5a53002", cap_wd);
      end
      for (int j = 0; j < 3; j++) begin
        @(negedge clk);
        tests++;
        if ({sel, enable, addr, wdata, strb} !== {1'b1, 1'b1, 32'h0000_3008, 32'hA5A5_3002, 4'hF}) begin
          errs++;
          $display("FAIL wait_hold%0d got sel=%b en=%b addr=%h wd=%h strb=%h exp 1 1 00003008 a5a53002 f",
                   j, sel, enable, addr, wdata, strb);
        end
      end
    end
    wait_done(200, cycles, to);
    wait_n = 0;
    tests++;
    if (to || log_addr.size() != 17) begin
      errs++;
      $display("FAIL wait_done got count=%0d timeout=%b exp 17 no timeout", log_addr.size(), to);
    end
    for (int i = 0; i < 17 && i < log_addr.size(); i++) begin
      tests++;
      if (log_addr[i] !== exp_addr(32'h3000, i) || log_wdata[i] !== exp_wdata(32'h3000, i, 32'h0)) begin
        errs++;
        $display("FAIL wait_xfer%0d got addr=%h wd=%h exp addr=%h wd=%h", i, log_addr[i],
                 log_wdata[i], exp_addr(32'h3000, i), exp_wdata(32'h3000, i, 32'h0));
      end
    end
  endtask

  task automatic test_slverr();
    int cycles;
    bit to;
    err_mask = 8'b0010_0010;
    start_seq(32'h0000_4000, 1'b1);
    wait_done(200, cycles, to);
    err_mask = '0;
    tests++;
    if (to || log_addr.size() != 17 || log_addr[16] !== 32'h0000_4100 ||
        log_wdata[16] !== 32'h0002_0000) begin
      errs++;
      $display("FAIL slverr_summary got count=%0d addr=%h wd=%h exp 17 00004100 00020000",
               log_addr.size(), log_addr[log_addr.size()-1], log_wdata[log_wdata.size()-1]);
    end
  endtask

  task automatic test_reset_mid();
    int cycles;
    bit to;
    bit found = 0;
    err_mask = 8'b0000_0010;
    start_seq(32'h0000_2000, 1'b1);
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (sel && enable && !write && addr == 32'h0000_200C) begin
        found = 1;
        break;
      end
    end
    tests++;
    if (!found) begin
      errs++;
      $display("FAIL rstmid_reach got no read of 0000200c exp access within 100 cycles");
    end
    rst_n = 1'b0;
    #0.1;
    tests++;
    if ({clk_en, addr, sel, enable, write, strb, prot, wdata} !== '0) begin
      errs++;
      $display("FAIL rstmid_outputs got addr=%h sel=%b en=%b wr=%b wd=%h clk_en=%b exp all zero",
               addr, sel, enable, write, wdata, clk_en);
    end
    err_mask = '0;
    clear_log();
    wait_cnt = 0;
    @(negedge clk);
    rst_n = 1'b1;
    wait_done(200, cycles, to);
    tests++;
    if (to || log_addr.size() != 17) begin
      errs++;
      $display("FAIL rstmid_done got count=%0d timeout=%b exp 17 no timeout", log_addr.size(), to);
    end
    for (int i = 0; i < 17 && i < log_addr.size(); i++) begin
      tests++;
      if (log_addr[i] !== exp_addr(32'h2000, i) || log_write[i] !== (i < 8 || i == 16) ||
          log_wdata[i] !== exp_wdata(32'h2000, i, 32'h0)) begin
        errs++;
        $display("FAIL rstmid_xfer%0d got addr=%h wr=%b wd=%h exp addr=%h wd=%h", i,
                 log_addr[i], log_write[i], log_wdata[i], exp_addr(32'h2000, i),
                 exp_wdata(32'h2000, i, 32'h0));
      end
    end
  endtask

  task automatic test_wrap();
    int cycles;
    bit to;
    start_seq(32'hFFFF_FFF8, 1'b1);
    wait_done(200, cycles, to);
    tests++;
    if (to || log_addr.size() != 17) begin
      errs++;
      $display("FAIL wrap_done got count=%0d timeout=%b exp 17 no timeout", log_addr.size(), to);
    end else begin
      tests++;
      if (log_addr[2] !== 32'h0 || log_wdata[2] !== 32'h5A5A_FFFA) begin
        errs++;
        $display("FAIL wrap_k2 got addr=%h wd=%h exp 00000000 5a5afffa", log_addr[2], log_wdata[2]);
      end
      tests++;
      if (log_addr[16] !== 32'h0000_00F8 || log_wdata[16] !== 32'h0) begin
        errs++;
        $display("FAIL wrap_summary got addr=%h wd=%h exp 000000f8 00000000", log_addr[16], log_wdata[16]);
      end
    end
  endtask

  initial begin
    ready  = 1'b1;
    slverr = 1'b0;
    rdata  = '0;
    test_reset();
    test_basic();
    test_memory();
    test_wait_states();
    test_slverr();
    test_reset_mid();
    test_wrap();
    $display("[TB] %0d tests run, %0d failed", tests, errs);
    $finish;
  end

endmodule

// File: doc/apb_emulator.md
Name: apb_emulator

Overview:
- Self-sequencing APB (AMBA3/APB4) master used as a stimulus source in block-level benches and emulation builds.
- After reset it runs a fixed sequence: a write phase, a read-back/compare phase, then one summary write reporting compare mismatches and slave errors.
- It then goes quiet and stays quiet until the next reset.
- The address base and data pattern are personalised by the static input emulator_id_i, so several instances can share one bus fabric.

Parameters:
- NUM_TRANS, 8, number of write transfers and number of read transfers (1..65535).
- START_DELAY, 2, clock cycles between reset release and the first SETUP phase (>=1).
- SUMMARY_OFFSET, 32'h0000_0100, address offset of the summary write relative to the base address.
- PROT, 3'b000, constant value driven on apb_prot_o.

Ports:
- apb_clk_i  input  1  APB clock; all state changes on the rising edge.
- apb_resetn_i  input  1  reset, asynchronous assert, active-low.
- apb_clk_en_o  output  1  high while the sequence is active (first SETUP through last transfer), low otherwise.
- apb_addr_o  output  32  PADDR.
- apb_sel_o  output  1  PSEL.
- apb_enable_o  output  1  PENABLE.
- apb_write_o  output  1  PWRITE.
- apb_strb_o  output  4  PSTRB; always 4'hF during a transfer.
- apb_prot_o  output  3  PPROT; equals PROT.
- apb_wdata_o  output  32  PWDATA.
- apb_ready_i  input  1  PREADY.
- apb_rdata_i  input  32  PRDATA.
- apb_slverr_i  input  1  PSLVERR.
- emulator_id_i  input  32  instance ID; used as the base address and as the data seed.

Behaviour:
- Reset (apb_resetn_i low, asynchronous): all outputs 0, including apb_prot_o. FSM goes to START; counters are cleared.
- Reset mid-operation: the transfer is abandoned immediately. After release the whole sequence restarts from index 0.
- FSM states: START, SETUP, ACCESS, GAP, DONE.
- START: waits START_DELAY rising edges after reset release. emulator_id_i is latched as BASE on the edge leaving START. Next state is SETUP.
- SETUP (one cycle):
  - apb_sel_o=1, apb_enable_o=0.
  - apb_addr_o, apb_write_o, apb_wdata_o, apb_strb_o=4'hF and apb_prot_o=PROT are all valid.
  - apb_clk_en_o=1.
  - Next state is ACCESS.
- ACCESS:
  - apb_sel_o=1, apb_enable_o=1; all other outputs held stable.
  - The FSM remains in ACCESS while apb_ready_i=0. There is no timeout.
  - On the edge with apb_ready_i=1, the transfer completes, apb_rdata_i and apb_slverr_i are sampled, and the next state is GAP.
- GAP (exactly one cycle): sel=0, enable=0; addr, write, wdata and strb hold their last values. Next state is SETUP of the next transfer, or DONE after the summary write.
- Minimum cost per transfer is 3 cycles (SETUP, ACCESS, GAP).
- Write phase, for k = 0..NUM_TRANS-1:
  - addr = BASE + 4*k.
  - wdata = {16'hA5A5, k[15:0]} XOR BASE.
  - apb_write_o = 1.
- Read phase, for k = 0..NUM_TRANS-1:
  - Same addresses as the write phase, apb_write_o = 0, wdata held at 0.
  - Expected data = the wdata of the same k.
- Counters:
  - MISMATCH (16-bit, saturating at 16'hFFFF) increments when the sampled rdata differs from the expected data.
  - SLVERR (16-bit, saturating) increments on every completed write-phase or read-phase transfer with apb_slverr_i=1.
- Summary write:
  - addr = BASE + SUMMARY_OFFSET, wdata = {SLVERR, MISMATCH}, apb_write_o = 1.
  - Its own apb_slverr_i is ignored.
- All address arithmetic is 32-bit and wraps modulo 2^32.
- DONE: all outputs 0 (apb_prot_o also 0) and apb_clk_en_o=0. The FSM stays in DONE until reset.
- Outputs are registered; no combinational path from inputs to outputs.

Test Plan:
- Scenario 1, basic sequence:
  - Stimulus: ID=0, ready=1, rdata=0, slverr=0; reset released at 6.6 ns with a 2 ns clock.
  - Required: first SETUP 2 edges after release with addr 0x0 and wdata 0xA5A50000.
  - Required: writes to 0x0..0x1C, then reads of 0x0..0x1C.
  - Required: summary write to 0x100 with wdata 0x00000008.
  - Required: clk_en low within 60 cycles, well inside a 100-cycle timeout.
- Scenario 2, memory-model slave: ID=0x1000 with a loop-back memory -> writes to 0x1000..0x101C with data 0xA5A51000 XOR k pattern; summary to 0x1100 with wdata 0x00000000.
- Scenario 3, wait states: ready held low for 3 cycles on write k=2 -> addr, wdata and sel stable with enable=1 through all wait cycles; the sequence completes with correct order.
- Scenario 4, slave errors: slverr=1 on reads k=1 and k=5, memory slave -> summary wdata 0x00020000.
- Scenario 5, reset mid-transfer: reset asserted during ACCESS of read k=3 -> outputs 0 immediately; after release the sequence restarts at a write to BASE with counters at zero.
- Scenario 6, address wrap: ID=0xFFFFFFF8 -> write k=2 goes to address 0x00000000; summary goes to 0x000000F8.
